// File: rtl/jtcus30_dcblk.sv
// Stereo DC-blocking high-pass (pole 1-2^-K) after the CUS30 DAC accumulator.
// Latency 3 clk strobe->dout_sample; one strobe buffered while busy, further ones dropped (overrun).
module jtcus30_dcblk #(
    parameter int SW = 13,
    parameter int K  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample,
    input  logic signed [SW-1:0] din_l,
    input  logic signed [SW-1:0] din_r,
    input  logic                 clr,
    output logic signed [SW-1:0] dout_l,
    output logic signed [SW-1:0] dout_r,
    output logic                 dout_sample,
    output logic                 sat,
    output logic                 overrun
);
    localparam int AW = SW + K + 2;
    localparam logic signed [AW-1:0] C_MAX = AW'((1 << (SW - 1)) - 1);
    localparam logic signed [AW-1:0] C_MIN = ~C_MAX;

    typedef enum logic [1:0] {IDLE, CALC_L, CALC_R, OUT} state_t;
    state_t r_state, w_next;

    logic signed [SW-1:0] r_hold_l, r_hold_r, r_pend_l, r_pend_r;
    logic signed [SW-1:0] r_xp_l, r_xp_r, r_y_l;
    logic signed [AW-1:0] r_a_l, r_a_r;
    logic                 r_pend;

    logic signed [SW-1:0] w_x, w_xp, w_yc;
    logic signed [AW-1:0] w_a, w_d, w_an, w_y;
    logic                 w_calc, w_clip, w_capture, w_drop;

    // Shared datapath: channel selected by the FSM state
    always_comb begin
        w_calc = (r_state == CALC_L) || (r_state == CALC_R);
        w_x    = (r_state == CALC_R) ? r_hold_r : r_hold_l;
        w_xp   = (r_state == CALC_R) ? r_xp_r   : r_xp_l;
        w_a    = (r_state == CALC_R) ? r_a_r    : r_a_l;
        w_d    = {{(AW-SW){w_x[SW-1]}}, w_x} - {{(AW-SW){w_xp[SW-1]}}, w_xp};
        w_an   = w_a + (w_d <<< K) - (w_a >>> K);
        w_y    = w_an >>> K;
        w_yc   = w_y[SW-1:0];
        w_clip = 1'b0;
        if (w_y > C_MAX) begin
            w_yc   = C_MAX[SW-1:0];
            w_clip = 1'b1;
        end else if (w_y < C_MIN) begin
            w_yc   = C_MIN[SW-1:0];
            w_clip = 1'b1;
        end
        w_capture = sample && w_calc && !r_pend;
        w_drop    = sample && (r_state != IDLE) && r_pend;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (sample) w_next = CALC_L;
            CALC_L:  w_next = CALC_R;
            CALC_R:  w_next = OUT;
            OUT:     w_next = (r_pend || sample) ? CALC_L : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_l <= '0;
            r_hold_r <= '0;
            r_pend_l <= '0;
            r_pend_r <= '0;
            r_pend   <= 1'b0;
            r_xp_l   <= '0;
            r_xp_r   <= '0;
            r_a_l    <= '0;
            r_a_r    <= '0;
            r_y_l    <= '0;
            dout_l   <= '0;
            dout_r   <= '0;
            sat      <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (sample) begin
                    r_hold_l <= din_l;
                    r_hold_r <= din_r;
                end
                CALC_L: begin
                    r_a_l  <= w_an;
                    r_xp_l <= r_hold_l;
                    r_y_l  <= w_yc;
                end
                CALC_R: begin
                    r_a_r  <= w_an;
                    r_xp_r <= r_hold_r;
                    dout_l <= r_y_l;
                    dout_r <= w_yc;
                end
                OUT: begin
                    // A strobe landing in OUT with nothing pending goes straight in
                    if (r_pend) begin
                        r_hold_l <= r_pend_l;
                        r_hold_r <= r_pend_r;
                        r_pend   <= 1'b0;
                    end else if (sample) begin
                        r_hold_l <= din_l;
                        r_hold_r <= din_r;
                    end
                end
                default: ;
            endcase
            if (w_capture) begin
                r_pend_l <= din_l;
                r_pend_r <= din_r;
                r_pend   <= 1'b1;
            end
            if (clr) begin
                sat     <= 1'b0;
                overrun <= 1'b0;
            end
            if (w_calc && w_clip) sat <= 1'b1;
            if (w_drop) overrun <= 1'b1;
        end
    end

    assign dout_sample = (r_state == OUT);
endmodule

// File: tb/tb_jtcus30_dcblk.sv
// Self-checking bench for jtcus30_dcblk: vector table plus recurrence-model scoreboard.
module tb_jtcus30_dcblk;
    localparam int SW = 13;
    localparam int K  = 8;
    localparam int AW = SW + K + 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 sample = 1'b0;
    logic                 clr = 1'b0;
    logic signed [SW-1:0] din_l = '0;
    logic signed [SW-1:0] din_r = '0;
    logic signed [SW-1:0] dout_l, dout_r;
    logic                 dout_sample, sat, overrun;

    jtcus30_dcblk #(.SW(SW), .K(K)) dut (
        .clk(clk), .rst(rst), .sample(sample), .din_l(din_l), .din_r(din_r),
        .clr(clr), .dout_l(dout_l), .dout_r(dout_r), .dout_sample(dout_sample),
        .sat(sat), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, pulses = 0, pulse_cyc = 0, strobe_cyc = 0;
    int last_l = 0;
    int q_l[$], q_r[$];

    logic signed [AW-1:0] m_a_l, m_a_r;
    logic signed [SW-1:0] m_xp_l, m_xp_r;

    typedef struct {
        int l, r, el, er;
    } vec_t;
    vec_t tbl[4];

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (dout_sample === 1'b1) begin
            pulses++;
            pulse_cyc = cyc;
            last_l = int'(dout_l);
            if (q_l.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_pulse: dout_l=%0d dout_r=%0d with no expected sample", dout_l, dout_r);
            end else begin
                chk("dout_l", dout_l, q_l.pop_front());
                chk("dout_r", dout_r, q_r.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_chan(input logic signed [SW-1:0] x, inout logic signed [AW-1:0] a,
                          inout logic signed [SW-1:0] xp, output int y);
        logic signed [AW-1:0] d, an, yy;
        d  = x;
        d  = d - xp;
        an = a + (d <<< K) - (a >>> K);
        yy = an >>> K;
        if (yy > AW'(4095))       y = 4095;
        else if (yy < -AW'(4096)) y = -4096;
        else                      y = int'(yy);
        a  = an;
        xp = x;
    endtask

    task automatic model_reset();
        m_a_l = '0; m_a_r = '0; m_xp_l = '0; m_xp_r = '0;
        q_l.delete(); q_r.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sample = 1'b0;
        clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        model_reset();
        tick();
    endtask

    // push: 1 = model it and expect an output, 0 = the strobe must be lost
    task automatic strobe(input int l, input int r, input bit push);
        int yl, yr;
        sample = 1'b1;
        din_l = SW'(l);
        din_r = SW'(r);
        strobe_cyc = cyc;
        if (push) begin
            m_chan(din_l, m_a_l, m_xp_l, yl);
            m_chan(din_r, m_a_r, m_xp_r, yr);
            q_l.push_back(yl);
            q_r.push_back(yr);
        end
        tick();
        sample = 1'b0;
    endtask

    task automatic wait_pulses(input int n, input int budget);
        for (int i = 0; i < budget && pulses < n; i++) tick();
        chk("pulse_arrived", pulses >= n, 1);
    endtask

    initial begin
        int p0, c0, prev;
        tbl[0] = '{l: 1000, r:    0, el: 1000, er:    0};
        tbl[1] = '{l: 1000, r:    0, el:  996, er:    0};
        tbl[2] = '{l: 1000, r: -500, el:  992, er: -500};
        tbl[3] = '{l:    0, r: -500, el:  -12, er: -499};

        do_reset();
        chk("rst_dout_l", dout_l, 0);
        chk("rst_dout_r", dout_r, 0);
        chk("rst_dout_sample", dout_sample, 0);
        chk("rst_sat", sat, 0);
        chk("rst_overrun", overrun, 0);

        // Vector table from reset: constant expectations
        for (int i = 0; i < 4; i++) begin
            p0 = pulses;
            q_l.push_back(tbl[i].el);
            q_r.push_back(tbl[i].er);
            strobe(tbl[i].l, tbl[i].r, 1'b0);
            wait_pulses(p0 + 1, 8);
            chk("latency", pulse_cyc - strobe_cyc, 3);
            chk("tbl_sat", sat, 0);
            tick();
        end
        tick(); tick(); tick();
        chk("hold_dout_l", dout_l, -12);
        chk("hold_dout_r", dout_r, -499);

        // Monotonic decay of a step
        do_reset();
        prev = 5000;
        for (int i = 0; i < 30; i++) begin
            p0 = pulses;
            strobe(1000, 0, 1'b1);
            wait_pulses(p0 + 1, 8);
            chk("decay_monotonic", last_l <= prev, 1);
            prev = last_l;
            tick();
        end

        // Constant input: DC removed
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            strobe(-500, -500, 1'b1);
            tick(); tick(); tick();
        end
        tick();
        chk("dc_abs_l_le1", (dout_l >= -1 && dout_l <= 1), 1);
        chk("dc_abs_r_le1", (dout_r >= -1 && dout_r <= 1), 1);
        chk("dc_sat", sat, 0);
        chk("dc_overrun", overrun, 0);

        // Saturation and clr
        do_reset();
        strobe(-4096, 0, 1'b1);
        tick(); tick(); tick();
        chk("sat_neg_ok", sat, 0);
        p0 = pulses;
        strobe(4095, 0, 1'b1);
        wait_pulses(p0 + 1, 8);
        chk("sat_dout_l", dout_l, 4095);
        chk("sat_set", sat, 1);
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("sat_clr", sat, 0);

        // clr coinciding with a clamp: set wins
        do_reset();
        strobe(-4096, 0, 1'b1);
        tick(); tick(); tick();
        strobe(4095, 0, 1'b1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick(); tick(); tick();
        chk("sat_set_wins", sat, 1);

        // Back-to-back strobes: second one buffered
        do_reset();
        p0 = pulses;
        c0 = cyc;
        strobe(100, 0, 1'b1);
        strobe(200, 0, 1'b1);
        wait_pulses(p0 + 1, 8);
        chk("b2b_first_latency", pulse_cyc - c0, 3);
        wait_pulses(p0 + 2, 8);
        chk("b2b_second_window", (pulse_cyc - c0 >= 6) && (pulse_cyc - c0 <= 7), 1);
        chk("b2b_dout_l", dout_l, 199);
        chk("b2b_overrun", overrun, 0);

        // Three back-to-back: third dropped, xp_l not disturbed
        do_reset();
        p0 = pulses;
        strobe(100, 0, 1'b1);
        strobe(200, 0, 1'b1);
        strobe(300, 0, 1'b0);
        for (int i = 0; i < 12; i++) tick();
        chk("drop_pulses", pulses - p0, 2);
        chk("drop_overrun", overrun, 1);
        strobe(200, 0, 1'b1);
        wait_pulses(p0 + 3, 8);
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("overrun_clr", overrun, 0);

        // Reset mid-computation aborts
        do_reset();
        strobe(1000, 0, 1'b1);
        p0 = pulses;
        tick();
        rst = 1'b1;
        model_reset();
        tick(); tick();
        chk("abort_dout_l", dout_l, 0);
        chk("abort_dout_r", dout_r, 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("abort_no_pulse", pulses, p0);
        strobe(1000, 0, 1'b1);
        wait_pulses(p0 + 1, 8);
        chk("abort_restart_l", dout_l, 1000);
        chk("abort_restart_latency", pulse_cyc - strobe_cyc, 3);

        tick(); tick();
        chk("scoreboard_drained", q_l.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
